// File: rtl/conv_pkg.sv
// Shared types and defaults for the output-feature-map tile scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int TI_DEF       = 16;
  localparam int TW_TILES_DEF = 4;
  localparam int ROW_GRP_DEF  = 5;
  localparam int OFM_ROWS_DEF = 65;
  localparam int CH_PER_GRP   = 8;
  // Four channel groups of eight channels: oc never exceeds 31.
  localparam int OC_W         = 5;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Tile-walk counters (ow, rg, tw, grp_base, oc) and output buffer address arithmetic.
module ofm_addr_gen
  import conv_pkg::*;
#(
  parameter int TI       = TI_DEF,
  parameter int TW_TILES = TW_TILES_DEF,
  parameter int ROW_GRP  = ROW_GRP_DEF,
  parameter int OFM_ROWS = OFM_ROWS_DEF,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic              pair,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic              pair_fit,
  output logic              chan_end,
  output logic [OC_W-1:0]   oc
);

  localparam int OW_W = cw(TI);
  localparam int RG_W = cw(ROW_GRP + 2);
  localparam int TW_W = cw(TW_TILES);
  localparam int GB_W = cw(OFM_ROWS + ROW_GRP);
  localparam logic [31:0] ROW_SZ = 32'(TI * TW_TILES);
  localparam logic [31:0] CH_SZ  = 32'(OFM_ROWS * TI * TW_TILES);

  logic [OW_W-1:0] ow;
  logic [RG_W-1:0] rg;
  logic [TW_W-1:0] tw;
  logic [GB_W-1:0] grp_base;

  logic [31:0] step;
  logic [31:0] rg_sum;
  logic [31:0] full;
  logic        ow_wrap;
  logic        rg_wrap;
  logic        tw_wrap;
  logic        gb_wrap;

  // The wrap chain is evaluated for the beat being accepted now; a pair
  // advances two rows at the end of a strip.
  always_comb begin
    step     = pair ? 32'd2 : 32'd1;
    rg_sum   = 32'(rg) + step;
    ow_wrap  = 32'(ow) == 32'(TI - 1);
    rg_wrap  = ow_wrap && (rg_sum >= 32'(ROW_GRP));
    tw_wrap  = rg_wrap && (32'(tw) == 32'(TW_TILES - 1));
    gb_wrap  = tw_wrap && (32'(grp_base) + 32'(ROW_GRP) >= 32'(OFM_ROWS));
    pair_fit = (32'(rg) + 32'd2) <= 32'(ROW_GRP);
    full     = 32'(oc) * CH_SZ + (32'(grp_base) + 32'(rg)) * ROW_SZ
             + 32'(tw) * 32'(TI) + 32'(ow);
    addr0    = ADDR_W'(full);
    addr1    = ADDR_W'(full + ROW_SZ);
  end

  assign chan_end = gb_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ow       <= '0;
      rg       <= '0;
      tw       <= '0;
      grp_base <= '0;
      oc       <= '0;
    end else if (adv) begin
      ow <= ow_wrap ? '0 : ow + 1'b1;
      if (ow_wrap) rg <= rg_wrap ? '0 : RG_W'(rg_sum);
      if (rg_wrap) tw <= tw_wrap ? '0 : tw + 1'b1;
      if (tw_wrap) grp_base <= gb_wrap ? '0 : grp_base + GB_W'(ROW_GRP);
      if (gb_wrap) oc <= oc + 1'b1;
    end
  end

endmodule

// File: rtl/ofm_tile_sched.sv
// Conv-layer output scheduler: launches the kernel, writes result samples to the
// output buffer in tile order, and flags protocol errors. Optional OFM_RELU_EN clamps negatives.
module ofm_tile_sched
  import conv_pkg::*;
#(
  parameter int TI             = TI_DEF,
  parameter int TW_TILES       = TW_TILES_DEF,
  parameter int ROW_GRP        = ROW_GRP_DEF,
  parameter int OFM_ROWS       = OFM_ROWS_DEF,
  parameter int OUT_DATA_WIDTH = 25,
  parameter int ADDR_W         = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                cfg_co,
  output logic                      acc_start,
  output logic [1:0]                acc_cfg_co,
  input  logic [OUT_DATA_WIDTH-1:0] ofm_port0,
  input  logic [OUT_DATA_WIDTH-1:0] ofm_port1,
  input  logic                      ofm_port0_v,
  input  logic                      ofm_port1_v,
  input  logic                      acc_end_conv,
  output logic                      wr_en0,
  output logic                      wr_en1,
  output logic [ADDR_W-1:0]         wr_addr0,
  output logic [ADDR_W-1:0]         wr_addr1,
  output logic [OUT_DATA_WIDTH-1:0] wr_data0,
  output logic [OUT_DATA_WIDTH-1:0] wr_data1,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  state_t state, nxt;

  logic              start_ok;
  logic              in_run;
  logic              any_v;
  logic              bad_solo;
  logic              bad_pair;
  logic              accept;
  logic              last_oc_hit;
  logic              final_acc;
  logic              err_set;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic              pair_fit;
  logic              chan_end;
  logic [OC_W-1:0]   oc;

  function automatic logic [OUT_DATA_WIDTH-1:0] shape(input logic [OUT_DATA_WIDTH-1:0] s);
`ifdef OFM_RELU_EN
    return s[OUT_DATA_WIDTH-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  ofm_addr_gen #(
    .TI       (TI),
    .TW_TILES (TW_TILES),
    .ROW_GRP  (ROW_GRP),
    .OFM_ROWS (OFM_ROWS),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .adv      (accept),
    .pair     (ofm_port1_v),
    .addr0    (a0),
    .addr1    (a1),
    .pair_fit (pair_fit),
    .chan_end (chan_end),
    .oc       (oc)
  );

  // Offending beats are dropped without touching the counters; an end from the
  // kernel is only clean when it coincides with (or follows) the final sample.
  always_comb begin
    start_ok    = (state == S_IDLE) && start;
    in_run      = (state == S_RUN);
    any_v       = ofm_port0_v | ofm_port1_v;
    bad_solo    = ofm_port1_v & ~ofm_port0_v;
    bad_pair    = ofm_port0_v & ofm_port1_v & ~pair_fit;
    accept      = in_run & ofm_port0_v & ~bad_pair;
    last_oc_hit = 32'(oc) == ((32'(acc_cfg_co) + 32'd1) * 32'(CH_PER_GRP) - 32'd1);
    final_acc   = accept & chan_end & last_oc_hit;
    err_set     = (~in_run & any_v)
                | (in_run & (bad_solo | bad_pair))
                | (in_run & acc_end_conv & ~final_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_LAUNCH;
      S_LAUNCH: nxt = S_RUN;
      S_RUN: begin
        if (acc_end_conv)   nxt = S_DONE;
        else if (final_acc) nxt = S_DRAIN;
      end
      S_DRAIN:  if (acc_end_conv) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    acc_start = (state == S_LAUNCH);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cfg_co <= '0;
      err        <= 1'b0;
    end else if (start_ok) begin
      acc_cfg_co <= cfg_co;
      err        <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en0   <= 1'b0;
      wr_en1   <= 1'b0;
      wr_addr0 <= '0;
      wr_addr1 <= '0;
      wr_data0 <= '0;
      wr_data1 <= '0;
    end else begin
      wr_en0 <= accept;
      wr_en1 <= accept & ofm_port1_v;
      if (accept) begin
        wr_addr0 <= a0;
        wr_data0 <= shape(ofm_port0);
      end
      if (accept && ofm_port1_v) begin
        wr_addr1 <= a1;
        wr_data1 <= shape(ofm_port1);
      end
    end
  end

endmodule

// File: tb/tb_ofm_tile_sched.sv
// Self-checking bench for ofm_tile_sched with a tile-index reference model.
module tb_ofm_tile_sched;

  localparam int TI   = 16;
  localparam int TWT  = 4;
  localparam int RG   = 5;
  localparam int ROWS = 65;
  localparam int DW   = 25;
  localparam int AW   = 18;
  localparam int W    = TI * TWT;
  localparam int CH   = ROWS * W;
  localparam int NG   = ROWS / RG;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cfg_co;
  logic          acc_start;
  logic [1:0]    acc_cfg_co;
  logic [DW-1:0] ofm_port0;
  logic [DW-1:0] ofm_port1;
  logic          ofm_port0_v;
  logic          ofm_port1_v;
  logic          acc_end_conv;
  logic          wr_en0;
  logic          wr_en1;
  logic [AW-1:0] wr_addr0;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data0;
  logic [DW-1:0] wr_data1;
  logic          busy;
  logic          done;
  logic          err;

  ofm_tile_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_co       (cfg_co),
    .acc_start    (acc_start),
    .acc_cfg_co   (acc_cfg_co),
    .ofm_port0    (ofm_port0),
    .ofm_port1    (ofm_port1),
    .ofm_port0_v  (ofm_port0_v),
    .ofm_port1_v  (ofm_port1_v),
    .acc_end_conv (acc_end_conv),
    .wr_en0       (wr_en0),
    .wr_en1       (wr_en1),
    .wr_addr0     (wr_addr0),
    .wr_addr1     (wr_addr1),
    .wr_data0     (wr_data0),
    .wr_data1     (wr_data1),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference position: global tile index plus rows filled and column within the strip.
  int m_t;
  int m_rows;
  int m_ow;

  function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] d);
`ifdef OFM_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic int m_addr();
    return (m_t / (TWT * NG)) * CH + (((m_t / TWT) % NG) * RG + m_rows) * W
         + (m_t % TWT) * TI + m_ow;
  endfunction

  task automatic m_adv(input int rows_step);
    m_ow = m_ow + 1;
    if (m_ow == TI) begin
      m_ow   = 0;
      m_rows = m_rows + rows_step;
      if (m_rows >= RG) begin
        m_rows = 0;
        m_t    = m_t + 1;
      end
    end
  endtask

  task automatic beat(input logic v0, input logic v1, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic endc);
    ofm_port0_v  = v0;
    ofm_port1_v  = v1;
    ofm_port0    = d0;
    ofm_port1    = d1;
    acc_end_conv = endc;
    @(posedge clk);
    #1;
    ofm_port0_v  = 1'b0;
    ofm_port1_v  = 1'b0;
    acc_end_conv = 1'b0;
    start        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic launch(input logic [1:0] c);
    cfg_co = c;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, acc_start, wr_en0, wr_en1, acc_cfg_co} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outs got=%b exp=0", {busy, done, err, acc_start, wr_en0, wr_en1, acc_cfg_co});
    end
    n_cmp++;
    if ({wr_addr0, wr_addr1} !== '0) begin
      n_bad++;
      $display("FAIL reset_addr got=%0d/%0d exp=0", wr_addr0, wr_addr1);
    end
    rst    = 1'b0;
    cfg_co = 2'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({acc_start, busy, acc_cfg_co} !== 4'b1110) begin
      n_bad++;
      $display("FAIL launch got=%b exp=1110", {acc_start, busy, acc_cfg_co});
    end
    cfg_co = 2'd1;
    start  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if ({acc_start, busy, acc_cfg_co} !== 4'b0110) begin
      n_bad++;
      $display("FAIL start_in_run got=%b exp=0110", {acc_start, busy, acc_cfg_co});
    end
  endtask

  task automatic test_group_rewind();
    int miss;
    int first;
    logic [DW-1:0] d;
    miss  = 0;
    first = -1;
    do_rst();
    launch(2'd0);
    for (int i = 0; i < 81; i++) begin
      d = DW'($urandom);
      beat(1'b1, 1'b0, d, '0, 1'b0);
      if (i < 80) begin
        if (wr_en0 !== 1'b1 || wr_en1 !== 1'b0 || wr_addr0 !== AW'((i / 16) * 64 + i % 16)
            || wr_data0 !== exp_data(d)) begin
          miss++;
          if (first < 0) first = i;
        end
      end else begin
        n_cmp++;
        if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(16)) begin
          n_bad++;
          $display("FAIL rewind_81st got=%0d en=%b exp=16", wr_addr0, wr_en0);
        end
      end
    end
    n_cmp++;
    if (miss !== 0) begin
      n_bad++;
      $display("FAIL rewind_seq got=%0d bad (first idx %0d) exp=0", miss, first);
    end
  endtask

  task automatic test_pair();
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    do_rst();
    launch(2'd0);
    d0 = DW'($urandom);
    d1 = DW'($urandom);
    beat(1'b1, 1'b1, d0, d1, 1'b0);
    n_cmp++;
    if ({wr_en0, wr_en1} !== 2'b11 || wr_addr0 !== AW'(0) || wr_addr1 !== AW'(64)) begin
      n_bad++;
      $display("FAIL pair_first got=%0d/%0d en=%b exp=0/64", wr_addr0, wr_addr1, {wr_en0, wr_en1});
    end
    n_cmp++;
    if (wr_data0 !== exp_data(d0) || wr_data1 !== exp_data(d1)) begin
      n_bad++;
      $display("FAIL pair_data got=%h/%h exp=%h/%h", wr_data0, wr_data1, exp_data(d0), exp_data(d1));
    end
    for (int i = 0; i < 15; i++) beat(1'b1, 1'b1, DW'($urandom), DW'($urandom), 1'b0);
    beat(1'b1, 1'b1, d0, d1, 1'b0);
    n_cmp++;
    if ({wr_en0, wr_en1} !== 2'b11 || wr_addr0 !== AW'(128) || wr_addr1 !== AW'(192)) begin
      n_bad++;
      $display("FAIL pair_17th got=%0d/%0d exp=128/192", wr_addr0, wr_addr1);
    end
  endtask

  task automatic test_illegal();
    do_rst();
    beat(1'b1, 1'b0, DW'(5), '0, 1'b0);
    n_cmp++;
    if ({err, wr_en0} !== 2'b10) begin
      n_bad++;
      $display("FAIL idle_valid got=%b exp=10", {err, wr_en0});
    end
    launch(2'd0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL start_clears_err got=%b exp=0", err);
    end
    beat(1'b0, 1'b1, '0, DW'(7), 1'b0);
    n_cmp++;
    if ({err, wr_en0, wr_en1} !== 3'b100) begin
      n_bad++;
      $display("FAIL port1_alone got=%b exp=100", {err, wr_en0, wr_en1});
    end
    beat(1'b1, 1'b0, DW'(9), '0, 1'b0);
    n_cmp++;
    if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(0)) begin
      n_bad++;
      $display("FAIL after_port1 got=%0d en=%b exp=0", wr_addr0, wr_en0);
    end
    for (int i = 1; i < 64; i++) beat(1'b1, 1'b0, DW'($urandom), '0, 1'b0);
    beat(1'b1, 1'b1, DW'(1), DW'(2), 1'b0);
    n_cmp++;
    if ({wr_en0, wr_en1} !== 2'b00) begin
      n_bad++;
      $display("FAIL bad_pair_dropped got=%b exp=00", {wr_en0, wr_en1});
    end
    beat(1'b1, 1'b0, DW'(3), '0, 1'b0);
    n_cmp++;
    if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(256)) begin
      n_bad++;
      $display("FAIL after_bad_pair got=%0d exp=256", wr_addr0);
    end
  endtask

  task automatic test_early_end();
    do_rst();
    launch(2'd1);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, DW'($urandom), '0, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_end_err got=%b exp=0", err);
    end
    beat(1'b1, 1'b0, DW'(11), '0, 1'b1);
    n_cmp++;
    if ({wr_en0, done, err} !== 3'b111 || wr_addr0 !== AW'(5)) begin
      n_bad++;
      $display("FAIL early_end got=%b addr=%0d exp=111 addr=5", {wr_en0, done, err}, wr_addr0);
    end
    idle(1);
    n_cmp++;
    if ({done, busy, err} !== 3'b001) begin
      n_bad++;
      $display("FAIL early_end_idle got=%b exp=001", {done, busy, err});
    end
  endtask

  task automatic test_relu();
    logic [DW-1:0] neg;
    logic [DW-1:0] pos;
    neg = 25'h1FFFFFF;
    pos = 25'h0ABCDE;
    do_rst();
    launch(2'd0);
    beat(1'b1, 1'b0, neg, '0, 1'b0);
`ifdef OFM_RELU_EN
    n_cmp++;
    if (wr_data0 !== 25'h0) begin
      n_bad++;
      $display("FAIL relu_neg got=%h exp=0", wr_data0);
    end
`else
    n_cmp++;
    if (wr_data0 !== 25'h1FFFFFF) begin
      n_bad++;
      $display("FAIL pass_neg got=%h exp=1ffffff", wr_data0);
    end
`endif
    beat(1'b1, 1'b1, pos, 25'h1000000, 1'b0);
    n_cmp++;
    if (wr_data0 !== 25'h0ABCDE || wr_data1 !== exp_data(25'h1000000)) begin
      n_bad++;
      $display("FAIL data_pair got=%h/%h exp=0abcde/%h", wr_data0, wr_data1, exp_data(25'h1000000));
    end
  endtask

  task automatic test_reset_mid();
    do_rst();
    launch(2'd2);
    for (int i = 0; i < 100; i++) beat(1'b1, 1'b0, DW'($urandom), '0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, err, acc_start, wr_en0, wr_en1, acc_cfg_co} !== 8'b0
        || wr_addr0 !== '0 || wr_data0 !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got=%b addr=%0d exp=0", {busy, done, err, acc_start, wr_en0, wr_en1, acc_cfg_co}, wr_addr0);
    end
    launch(2'd0);
    beat(1'b1, 1'b0, DW'(1), '0, 1'b0);
    n_cmp++;
    if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(0) || err !== 1'b0) begin
      n_bad++;
      $display("FAIL restart got=%0d en=%b err=%b exp=0/1/0", wr_addr0, wr_en0, err);
    end
  endtask

  task automatic test_full_run();
    int miss;
    int first;
    int exp_a;
    miss  = 0;
    first = -1;
    do_rst();
    launch(2'd0);
    for (int k = 0; k < 33280; k++) begin
      beat(1'b1, 1'b0, DW'(k), '0, 1'b0);
      exp_a = (k / 4160) * CH + (((k / 320) % NG) * RG + (k / 16) % RG) * W
            + ((k / 80) % TWT) * TI + k % 16;
      if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(exp_a)) begin
        miss++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (miss !== 0) begin
      n_bad++;
      $display("FAIL full_run_addrs got=%0d bad (first %0d) exp=0", miss, first);
    end
    n_cmp++;
    if (wr_addr0 !== AW'(33279) || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL full_run_last got=%0d busy=%b exp=33279 busy=1", wr_addr0, busy);
    end
    idle(3);
    n_cmp++;
    if ({busy, done, err, wr_en0} !== 4'b1000) begin
      n_bad++;
      $display("FAIL drain_wait got=%b exp=1000", {busy, done, err, wr_en0});
    end
    beat(1'b0, 1'b0, '0, '0, 1'b1);
    n_cmp++;
    if ({done, err} !== 2'b10) begin
      n_bad++;
      $display("FAIL full_run_done got=%b exp=10", {done, err});
    end
    idle(1);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL full_run_idle got=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_random_run();
    int miss;
    int first;
    int ea;
    int total;
    int guard;
    logic pr;
    logic fin;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    miss   = 0;
    first  = -1;
    total  = TWT * NG * 8;
    guard  = 0;
    pr     = 1'b0;
    fin    = 1'b0;
    m_t    = 0;
    m_rows = 0;
    m_ow   = 0;
    do_rst();
    launch(2'd0);
    while (m_t < total && guard < 60000) begin
      guard++;
      if ($urandom_range(0, 7) == 0) begin
        beat(1'b0, 1'b0, '0, '0, 1'b0);
        if ({wr_en0, wr_en1} !== 2'b00) begin
          miss++;
          if (first < 0) first = guard;
        end
      end else begin
        if (m_ow == 0) pr = (m_rows + 2 <= RG) && ($urandom_range(0, 1) == 1);
        ea = m_addr();
        m_adv(pr ? 2 : 1);
        fin = (m_t == total);
        d0  = DW'($urandom);
        d1  = DW'($urandom);
        beat(1'b1, pr, d0, d1, fin);
        if (wr_en0 !== 1'b1 || wr_en1 !== pr || wr_addr0 !== AW'(ea) || wr_data0 !== exp_data(d0)
            || (pr && (wr_addr1 !== AW'(ea + W) || wr_data1 !== exp_data(d1)))) begin
          miss++;
          if (first < 0) first = guard;
        end
      end
    end
    n_cmp++;
    if (miss !== 0 || m_t !== total) begin
      n_bad++;
      $display("FAIL random_run got=%0d bad (first beat %0d) tiles=%0d exp=0 bad tiles=%0d", miss, first, m_t, total);
    end
    n_cmp++;
    if ({done, err} !== 2'b10) begin
      n_bad++;
      $display("FAIL end_with_final got=%b exp=10", {done, err});
    end
    idle(1);
    n_cmp++;
    if ({done, busy, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL random_idle got=%b exp=000", {done, busy, err});
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    cfg_co       = 2'd0;
    ofm_port0    = '0;
    ofm_port1    = '0;
    ofm_port0_v  = 1'b0;
    ofm_port1_v  = 1'b0;
    acc_end_conv = 1'b0;
    m_t          = 0;
    m_rows       = 0;
    m_ow         = 0;
    test_reset();
    test_group_rewind();
    test_pair();
    test_illegal();
    test_early_end();
    test_relu();
    test_reset_mid();
    test_full_run();
    test_random_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofm_tile_sched.md
OFM_TILE_SCHED -- requirements
Module: ofm_tile_sched

Interface
REQ-001 SHALL have parameter TI, default 16: output tile width in columns.
REQ-002 SHALL have parameter TW_TILES, default 4: column tiles per row (row width W = TI*TW_TILES = 64).
REQ-003 SHALL have parameter ROW_GRP, default 5: rows per row group.
REQ-004 SHALL have parameter OFM_ROWS, default 65: stored rows per output channel.
REQ-005 SHALL have parameter OUT_DATA_WIDTH, default 25: ofm sample width.
REQ-006 SHALL have parameter ADDR_W, default 18: output buffer address width.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1: one-cycle request to run one conv layer.
REQ-010 SHALL have port cfg_co, input, 2: output channel groups minus 1; channels = (cfg_co+1)*8.
REQ-011 SHALL have ports acc_start (output, 1) and acc_cfg_co (output, 2): start pulse and held config driven to the conv kernel.
REQ-012 SHALL have ports ofm_port0, ofm_port1 (input, OUT_DATA_WIDTH), ofm_port0_v, ofm_port1_v (input, 1) and acc_end_conv (input, 1): results and completion from the kernel.
REQ-013 SHALL have ports wr_en0, wr_en1 (output, 1), wr_addr0, wr_addr1 (output, ADDR_W) and wr_data0, wr_data1 (output, OUT_DATA_WIDTH): output buffer write ports.
REQ-014 SHALL have ports busy, done, err (output, 1 each): status; done is a 1-cycle pulse; err is sticky.

Function
REQ-015 SHALL implement FSM IDLE -> LAUNCH -> RUN -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: on start=1, capture cfg_co into acc_cfg_co, clear all counters and err, and go to LAUNCH; busy=0 only in IDLE.
REQ-017 LAUNCH: assert acc_start for exactly one cycle, then go to RUN.
REQ-018 Counters: ow (0..TI-1), rg (rows done in the current group, 0..ROW_GRP-1), tw (0..TW_TILES-1), grp_base (row of the group start), oc (channel).
REQ-019 Sample address = oc*OFM_ROWS*W + (grp_base+rg)*W + tw*TI + ow, computed at full width and truncated to ADDR_W.
REQ-020 port0_v alone: write port0 at the row grp_base+rg; ow increments; at ow wrap, rg increments.
REQ-021 port0_v and port1_v together: port0 goes to row r and port1 to row r+1, where r = grp_base+rg; at ow wrap, rg increments by 2.
REQ-022 When rg reaches ROW_GRP, rg clears and tw increments; when tw wraps, grp_base increments by ROW_GRP; when grp_base reaches OFM_ROWS, grp_base clears and oc increments.
REQ-023 Writes SHALL be registered with 1-cycle latency: wr_en/wr_addr/wr_data appear the cycle after the valid.
REQ-024 After the last sample of channel (cfg_co+1)*8-1, go to DRAIN; DRAIN waits for acc_end_conv, then goes to DONE.
REQ-025 acc_end_conv in RUN before the count is complete: go to DONE and set err.
REQ-026 If acc_end_conv and the final sample arrive in the same cycle, the write SHALL be performed and the FSM goes to DONE without err.
REQ-027 DONE: pulse done for 1 cycle, then return to IDLE.
REQ-028 The following SHALL set err, drop the offending sample(s) and leave counters unchanged: port1_v without port0_v; a pair when rg+2 > ROW_GRP; any valid outside RUN.
REQ-029 start outside IDLE SHALL be ignored.

Reset
REQ-030 rst=1 at any clock edge, including mid-run, SHALL return the FSM to IDLE and clear all counters.
REQ-031 During rst, all outputs SHALL be 0, acc_cfg_co SHALL be 0 and err SHALL be cleared.

Configuration
REQ-032 With macro OFM_RELU_EN defined, wr_data SHALL be forced to 0 when the signed sample is negative.
REQ-033 Without OFM_RELU_EN, wr_data SHALL equal the input sample unchanged.

Structure
REQ-034 Shared package conv_pkg SHALL hold the FSM state enum, default TI/TW_TILES/ROW_GRP/OFM_ROWS, and the channels-per-group constant (8).
REQ-035 Address counters SHALL live in one sub-module ofm_addr_gen (counters + address arithmetic); the FSM, error checks and write registers SHALL remain in the top.

Verification
REQ-036 Full run, cfg_co=0, single valids -> 33280 writes; final wr_addr0=33279; then acc_end_conv -> one done pulse, err=0.
REQ-037 Group rewind: 80 consecutive port0_v -> addresses 0..15, 64..79, ..., 256..271; 81st write at addr 16.
REQ-038 Pair valid at group start -> wr_addr0=0, wr_addr1=64 in the same cycle; after 16 pairs, the next pair writes addrs 128 and 192.
REQ-039 port1_v=1 with port0_v=0 -> err=1, no write, next port0_v writes addr 0.
REQ-040 Sample 25'h1FFFFFF -> wr_data0=0 with OFM_RELU_EN defined, 25'h1FFFFFF without it.
REQ-041 rst asserted after 100 writes -> all outputs 0 next cycle; a new start rewrites from addr 0.
